// File: rtl/seq_pkg.sv
// Shared definitions for the sequence-detector path (serializer + detector).
//   seq_state_t   : serializer FSM state (1 bit: IDLE, SHIFT)
//   SEQ_WIDTH_DEF : default serializer word width
//   IDLE_BIT_DEF  : default value on the serial line when no word is in flight
package seq_pkg;

  typedef enum logic {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } seq_state_t;

  localparam int   SEQ_WIDTH_DEF = 8;
  localparam logic IDLE_BIT_DEF  = 1'b0;

endpackage

// File: rtl/bit_serializer_if.sv
// Handshake / stream bundle for bit_serializer.
//   en        : bit-rate strobe
//   in_data   : parallel word, in_valid / in_ready handshake
//   out_bit   : serial bit, out_valid qualifies it
//   busy      : word in flight
//   word_done : one-cycle pulse after the last bit of a word is consumed
// slave  = serializer side, master = producer / consumer side.
interface bit_serializer_if #(
  parameter int WIDTH = seq_pkg::SEQ_WIDTH_DEF
);
  logic             en;
  logic [WIDTH-1:0] in_data;
  logic             in_valid;
  logic             in_ready;
  logic             out_bit;
  logic             out_valid;
  logic             busy;
  logic             word_done;

  modport slave (
    input  en, in_data, in_valid,
    output in_ready, out_bit, out_valid, busy, word_done
  );

  modport master (
    output en, in_data, in_valid,
    input  in_ready, out_bit, out_valid, busy, word_done
  );
endinterface

// File: rtl/bit_serializer.sv
// Parallel-to-serial front end for the sequence detector.
// Accepts WIDTH-bit words on a valid/ready handshake and emits one bit per
// cycle with en=1. A word offered while the last bit is being consumed is
// loaded on the same edge, so back-to-back words form a gap-free stream.
// Ports:
//   clock : rising-edge clock
//   reset : asynchronous, active-high
//   bus   : bit_serializer_if.slave (en, in_data/in_valid/in_ready,
//           out_bit, out_valid, busy, word_done)
module bit_serializer
  import seq_pkg::*;
#(
  parameter int   WIDTH     = SEQ_WIDTH_DEF,
  parameter bit   MSB_FIRST = 1'b1,
  parameter logic IDLE_BIT  = IDLE_BIT_DEF
) (
  input  logic              clock,
  input  logic              reset,
  bit_serializer_if.slave   bus
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  seq_state_t       state, state_nxt;
  logic [WIDTH-1:0] sh, sh_nxt;
  logic [CW-1:0]    cnt, cnt_nxt;
  logic             done_q, done_nxt;
  logic             rdy;
  logic             last;

  // cnt counts bits already consumed, so this marks the final bit on the line
  assign last = (cnt == CW'(WIDTH - 1));

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state  <= IDLE;
      sh     <= '0;
      cnt    <= '0;
      done_q <= 1'b0;
    end else begin
      state  <= state_nxt;
      sh     <= sh_nxt;
      cnt    <= cnt_nxt;
      done_q <= done_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    sh_nxt    = sh;
    cnt_nxt   = cnt;
    done_nxt  = 1'b0;
    rdy       = 1'b0;
    unique case (state)
      IDLE: begin
        rdy = 1'b1;
        if (bus.in_valid) begin
          sh_nxt    = bus.in_data;
          cnt_nxt   = '0;
          state_nxt = SHIFT;
        end
      end
      SHIFT: begin
        if (bus.en) begin
          if (!last) begin
            sh_nxt  = MSB_FIRST ? {sh[WIDTH-2:0], 1'b0} : {1'b0, sh[WIDTH-1:1]};
            cnt_nxt = cnt + CW'(1);
          end else begin
            // last bit leaves this edge: hand the slot straight to the next word
            done_nxt = 1'b1;
            rdy      = 1'b1;
            if (bus.in_valid) begin
              sh_nxt  = bus.in_data;
              cnt_nxt = '0;
            end else begin
              state_nxt = IDLE;
            end
          end
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // reset masks the combinational ready so nothing is taken while held
  assign bus.in_ready  = rdy & ~reset;
  assign bus.out_valid = (state == SHIFT);
  assign bus.busy      = (state == SHIFT);
  assign bus.out_bit   = (state == SHIFT) ? (MSB_FIRST ? sh[WIDTH-1] : sh[0]) : IDLE_BIT;
  assign bus.word_done = done_q;

endmodule

// File: tb/tb_bit_serializer.sv
module tb_bit_serializer;
  import seq_pkg::*;

  localparam int   W  = 8;
  localparam logic IB = IDLE_BIT_DEF;

  logic clock = 1'b0;
  logic reset = 1'b1;
  always #5 clock = ~clock;

  bit_serializer_if #(.WIDTH(W)) b0 ();
  bit_serializer_if #(.WIDTH(W)) b1 ();

  bit_serializer #(.WIDTH(W), .MSB_FIRST(1'b1), .IDLE_BIT(IB)) dut_msb (
    .clock(clock), .reset(reset), .bus(b0.slave));
  bit_serializer #(.WIDTH(W), .MSB_FIRST(1'b0), .IDLE_BIT(IB)) dut_lsb (
    .clock(clock), .reset(reset), .bus(b1.slave));

  int total = 0;
  int bad   = 0;

  // reference: pending bits of the word in flight, in line order
  bit   q0[$];
  bit   q1[$];
  logic done_e = 1'b0;

  function automatic void chk(string tag, logic obs, logic exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
    end
  endfunction

  task automatic drive(input logic e, input logic v, input logic [W-1:0] d);
    b0.en = e; b0.in_valid = v; b0.in_data = d;
    b1.en = e; b1.in_valid = v; b1.in_data = d;
  endtask

  task automatic check_outputs(input logic rdy_e);
    chk("msb_ready", b0.in_ready,  rdy_e);
    chk("msb_valid", b0.out_valid, q0.size() != 0);
    chk("msb_bit",   b0.out_bit,   (q0.size() != 0) ? q0[0] : IB);
    chk("msb_busy",  b0.busy,      q0.size() != 0);
    chk("msb_done",  b0.word_done, done_e);
    chk("lsb_ready", b1.in_ready,  rdy_e);
    chk("lsb_valid", b1.out_valid, q1.size() != 0);
    chk("lsb_bit",   b1.out_bit,   (q1.size() != 0) ? q1[0] : IB);
    chk("lsb_done",  b1.word_done, done_e);
  endtask

  // One cycle: drive after the falling edge, check, then advance the model
  // across the rising edge.
  task automatic cyc(input logic e, input logic v, input logic [W-1:0] d, output logic acc);
    logic rdy_e;
    drive(e, v, d);
    #1;
    rdy_e = (q0.size() == 0) || (q0.size() == 1 && e);
    check_outputs(rdy_e);
    @(posedge clock);
    acc    = rdy_e && v;
    done_e = 1'b0;
    if (e && q0.size() != 0) begin
      void'(q0.pop_front());
      void'(q1.pop_front());
      if (q0.size() == 0) done_e = 1'b1;
    end
    if (acc) begin
      for (int i = W - 1; i >= 0; i--) q0.push_back(d[i]);
      for (int i = 0; i < W; i++)      q1.push_back(d[i]);
    end
    @(negedge clock);
  endtask

  task automatic send(input logic [W-1:0] d);
    logic acc;
    int   n;
    acc = 1'b0;
    n   = 0;
    while (!acc && n < 40) begin
      cyc(1'b1, 1'b1, d, acc);
      n++;
    end
    chk("send_accepted", acc, 1'b1);
  endtask

  // drain with en=1, or with en pattern 1,0,0,1,0,0,... when pat is set
  task automatic drain(input bit pat);
    logic acc;
    int   n;
    n = 0;
    while ((q0.size() != 0 || done_e) && n < 60) begin
      cyc(pat ? (n % 3 == 0) : 1'b1, 1'b0, '0, acc);
      n++;
    end
    chk("drain_in_time", n < 60, 1'b1);
    cyc(1'b1, 1'b0, '0, acc);
  endtask

  initial begin
    logic         acc;
    logic         have;
    logic [W-1:0] w;
    drive(1'b0, 1'b0, '0);

    // reset state
    #1;
    check_outputs(1'b0);
    @(negedge clock);
    reset = 1'b0;

    // single word, en tied high
    send(8'hA6);
    drain(1'b0);

    // back-to-back words, valid held high
    send(8'hA6);
    send(8'h0F);
    drain(1'b0);

    // paced strobe
    cyc(1'b1, 1'b1, 8'hA6, acc);
    chk("paced_accept", acc, 1'b1);
    drain(1'b1);

    // word offered while another is in flight
    send(8'hC3);
    cyc(1'b1, 1'b0, '0, acc);
    cyc(1'b1, 1'b0, '0, acc);
    send(8'h55);
    drain(1'b0);

    // reset mid-word: outputs must drop before any clock edge
    send(8'hFF);
    repeat (4) cyc(1'b1, 1'b0, '0, acc);
    #2;
    reset = 1'b1;
    #1;
    q0.delete();
    q1.delete();
    done_e = 1'b0;
    check_outputs(1'b0);
    @(negedge clock);
    #1;
    check_outputs(1'b0);
    @(negedge clock);
    reset = 1'b0;
    send(8'h81);
    drain(1'b0);

    // single set bit, shows bit order on both instances
    send(8'h01);
    drain(1'b0);

    // random words and strobes
    have = 1'b0;
    w    = '0;
    for (int k = 0; k < 400; k++) begin
      if (!have && $urandom_range(0, 2) != 0) begin
        have = 1'b1;
        w    = W'($urandom);
      end
      cyc($urandom_range(0, 3) != 0, have, w, acc);
      if (acc) have = 1'b0;
    end
    drain(1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
